hazard_unit: RTL and testbench

//  Pipeline hazard and forwarding controller: the control end of the E-stage pipeline register.

---
 rtl/hazard_unit_pkg.sv | 20 ++
 rtl/hazard_unit_if.sv | 21 ++
 rtl/hazard_unit_sat_counter.sv | 18 +
 rtl/hazard_unit.sv | 75 +++++++
 tb/tb_hazard_unit.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: forward-select encodings, FSM states and register-match helpers
package hazard_unit_pkg;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {RUN, STALL} state_e;

    // $zero is hardwired, so it can never create a dependency
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic we_m, input logic [4:0] dst_m,
                                           input logic we_w, input logic [4:0] dst_w,
                                           input logic [4:0] src);
        return (we_m && reg_hit(dst_m, src)) ? FWD_M :
               (we_w && reg_hit(dst_w, src)) ? FWD_W : FWD_RF;
    endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-stage tags/controls in, stall/forward/stat signals out
interface hazard_unit_if #(parameter int CNT_W = 16);
    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic BranchD, RFWEE, MtoRFSelE, RFWEM, MtoRFSelM, RFWEW, CntClr;
    logic StallF, StallD, FlushE, ForwardAD, ForwardBD, HazErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCycles, StallEvents;

    modport master (
        output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
               BranchD, RFWEE, MtoRFSelE, RFWEM, MtoRFSelM, RFWEW, CntClr,
        input  StallF, StallD, FlushE, ForwardAD, ForwardBD, HazErr,
               ForwardAE, ForwardBE, StallCycles, StallEvents
    );
    modport slave (
        input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
               BranchD, RFWEE, MtoRFSelE, RFWEM, MtoRFSelM, RFWEW, CntClr,
        output StallF, StallD, FlushE, ForwardAD, ForwardBD, HazErr,
               ForwardAE, ForwardBE, StallCycles, StallEvents
    );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clear wins over increment
module sat_counter #(parameter int W = 16) (
    input  logic         clk,
    input  logic         RST,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge RST)
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use/branch stall detection, operand forwarding, stall FSM,
// stall watchdog and saturating stall statistics.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input logic        clk,
    input logic        RST,
    hazard_unit_if.slave hz
);
    localparam int               RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);

    logic lwstall, brstall, stall, dep_e, dep_m;
    state_e state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic hazerr_q, hazerr_d;

    always_comb begin
        dep_e   = reg_hit(hz.WriteRegE, hz.rsD) || reg_hit(hz.WriteRegE, hz.rtD);
        dep_m   = reg_hit(hz.WriteRegM, hz.rsD) || reg_hit(hz.WriteRegM, hz.rtD);
        lwstall = hz.MtoRFSelE && dep_e;
        brstall = hz.BranchD && ((hz.RFWEE && dep_e) || (hz.MtoRFSelM && dep_m));
        stall   = (lwstall || brstall) && !RST;
    end

    assign hz.StallF    = stall;
    assign hz.StallD    = stall;
    assign hz.FlushE    = stall || RST;
    assign hz.ForwardAE = RST ? FWD_RF : fwd_sel(hz.RFWEM, hz.WriteRegM, hz.RFWEW, hz.WriteRegW, hz.rsE);
    assign hz.ForwardBE = RST ? FWD_RF : fwd_sel(hz.RFWEM, hz.WriteRegM, hz.RFWEW, hz.WriteRegW, hz.rtE);
    assign hz.ForwardAD = !RST && hz.RFWEM && reg_hit(hz.WriteRegM, hz.rsD);
    assign hz.ForwardBD = !RST && hz.RFWEM && reg_hit(hz.WriteRegM, hz.rtD);

    // run_q counts consecutive stall cycles, starting at 1 on the RUN->STALL edge
    always_comb begin
        state_d  = stall ? STALL : RUN;
        run_d    = (hz.CntClr || !stall) ? '0 :
                   (state_q == RUN)      ? RUN_W'(1) :
                   (run_q == RUN_SAT)    ? run_q : run_q + 1'b1;
        hazerr_d = !hz.CntClr && (hazerr_q || (run_d > RUN_LIM));
    end

    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            state_q  <= RUN;
            run_q    <= '0;
            hazerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            hazerr_q <= hazerr_d;
        end

    assign hz.HazErr = hazerr_q;

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .RST   (RST),
        .inc_i (stall),
        .clr_i (hz.CntClr),
        .cnt_o (hz.StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_events (
        .clk   (clk),
        .RST   (RST),
        .inc_i (stall && (state_q == RUN)),
        .clr_i (hz.CntClr),
        .cnt_o (hz.StallEvents)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed steps; expectations queued at drive time, popped at sample time
module tb_hazard_unit;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(16)) hz();

    hazard_unit #(.CNT_W(16), .MAX_STALL(4)) dut (
        .clk (clk),
        .RST (RST),
        .hz  (hz.slave)
    );

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.BranchD = 0; hz.RFWEE = 0; hz.MtoRFSelE = 0;
        hz.RFWEM = 0; hz.MtoRFSelM = 0; hz.RFWEW = 0; hz.CntClr = 0;
    endtask

    task automatic exp_stall(input string t, input logic v);
        push({t, "_StallF"}, 32'(v));
        push({t, "_StallD"}, 32'(v));
        push({t, "_FlushE"}, 32'(v));
        #1;
        pop_chk(32'(hz.StallF));
        pop_chk(32'(hz.StallD));
        pop_chk(32'(hz.FlushE));
    endtask

    task automatic exp_cnt(input string t, input int cyc, input int evt, input logic err);
        push({t, "_StallCycles"}, 32'(cyc));
        push({t, "_StallEvents"}, 32'(evt));
        push({t, "_HazErr"}, 32'(err));
        pop_chk(32'(hz.StallCycles));
        pop_chk(32'(hz.StallEvents));
        pop_chk(32'(hz.HazErr));
    endtask

    initial begin
        clear_in();
        #2;
        push("rst_FlushE", 1);   pop_chk(32'(hz.FlushE));
        push("rst_StallD", 0);   pop_chk(32'(hz.StallD));
        push("rst_ForwardAE", 0); pop_chk(32'(hz.ForwardAE));
        exp_cnt("rst", 0, 0, 0);
        tick();
        RST = 1'b0;
        exp_stall("idle", 0);

        hz.rsE = 5; hz.rtE = 5; hz.RFWEM = 1; hz.WriteRegM = 5; hz.RFWEW = 1; hz.WriteRegW = 5;
        hz.rsD = 5; hz.rtD = 7;
        push("fwd_AE_M", 2); push("fwd_BE_M", 2); push("fwd_AD", 1); push("fwd_BD", 0);
        #1;
        pop_chk(32'(hz.ForwardAE)); pop_chk(32'(hz.ForwardBE));
        pop_chk(32'(hz.ForwardAD)); pop_chk(32'(hz.ForwardBD));
        hz.RFWEM = 0;
        push("fwd_AE_W", 1); push("fwd_AD_off", 0);
        #1;
        pop_chk(32'(hz.ForwardAE)); pop_chk(32'(hz.ForwardAD));
        clear_in();

        hz.RFWEM = 1; hz.WriteRegM = 0; hz.rsE = 0; hz.rsD = 0;
        push("r0_AE", 0); push("r0_AD", 0);
        #1;
        pop_chk(32'(hz.ForwardAE)); pop_chk(32'(hz.ForwardAD));
        hz.MtoRFSelE = 1; hz.WriteRegE = 0;
        exp_stall("r0_lw", 0);
        clear_in();
        tick();

        hz.MtoRFSelE = 1; hz.WriteRegE = 8; hz.rtD = 8;
        exp_stall("lw", 1);
        tick();
        clear_in();
        tick();
        exp_cnt("lw", 1, 1, 0);

        hz.BranchD = 1; hz.rsD = 3; hz.RFWEE = 1; hz.WriteRegE = 3;
        exp_stall("br_e", 1);
        tick();
        hz.RFWEE = 0; hz.WriteRegE = 0; hz.MtoRFSelM = 1; hz.WriteRegM = 3;
        exp_stall("br_m", 1);
        tick();
        clear_in();
        tick();
        exp_cnt("br", 3, 2, 0);

        hz.MtoRFSelE = 1; hz.WriteRegE = 4; hz.rsD = 4; hz.BranchD = 1; hz.RFWEE = 1;
        exp_stall("both", 1);
        tick();
        clear_in();
        tick();
        exp_cnt("both", 4, 3, 0);

        hz.MtoRFSelE = 1; hz.WriteRegE = 9; hz.rsD = 9;
        for (int i = 1; i <= 4; i++) tick();
        exp_cnt("wd4", 8, 4, 0);
        tick();
        exp_cnt("wd5", 9, 4, 1);
        clear_in();
        tick();
        exp_cnt("wd_sticky", 9, 4, 1);

        hz.MtoRFSelE = 1; hz.WriteRegE = 9; hz.rsD = 9; hz.CntClr = 1;
        tick();
        exp_cnt("clr", 0, 0, 0);
        hz.CntClr = 0;
        tick();
        exp_cnt("clr_fsm", 1, 0, 0);

        hz.rsE = 5; hz.RFWEM = 1; hz.WriteRegM = 5;
        push("pre_rst_AE", 2);
        #1;
        pop_chk(32'(hz.ForwardAE));
        RST = 1'b1;
        push("mid_rst_StallD", 0); push("mid_rst_StallF", 0); push("mid_rst_FlushE", 1);
        push("mid_rst_AE", 0);
        #1;
        pop_chk(32'(hz.StallD)); pop_chk(32'(hz.StallF)); pop_chk(32'(hz.FlushE));
        pop_chk(32'(hz.ForwardAE));
        exp_cnt("mid_rst", 0, 0, 0);
        RST = 1'b0;
        exp_stall("post_rst", 1);
        tick();
        exp_cnt("post_rst", 1, 1, 0);
        clear_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
